// File: rtl/ula_flags.sv
// 64-bit add/subtract unit with registered result and condition flags.
// One shared adder serves both operations; flags feed compare and branch logic.
module ula_flags #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             lt,
  output logic             ltu
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_c;
  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             zero_c;
  logic             neg_c;
  logic             ovf_c;
  logic             lt_c;
  logic             ltu_c;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;

  // Subtract is s1 + ~s2 + 1; carry-out of 1 means no borrow.
  assign b_c = s2 ^ {WIDTH{sub}};
  assign {carry_c, sum_c} = {1'b0, s1} + {1'b0, b_c}
                          + {{WIDTH{1'b0}}, sub};

  assign zero_c = (sum_c == '0);
  assign neg_c  = sum_c[MSB];
  assign ovf_c  = (s1[MSB] == b_c[MSB]) && (sum_c[MSB] != s1[MSB]);
  assign lt_c   = neg_c ^ ovf_c;
  assign ltu_c  = ~carry_c;

  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    if (en) begin
      res_d   = sum_c;
      zero_d  = zero_c;
      neg_d   = neg_c;
      carry_d = carry_c;
      ovf_d   = ovf_c;
      lt_d    = lt_c;
      ltu_d   = ltu_c;
    end
  end

  // Zero is cleared in reset too: it doubles as a "no result yet" marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
    end
  end

  assign res   = res_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign lt    = lt_q;
  assign ltu   = ltu_q;

endmodule

// File: tb/tb_ula_flags.sv
// Directed bench for ula_flags: hand-computed vectors checked
// with immediate assertions one cycle after capture.
module tb_ula_flags;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [63:0] s1;
  logic [63:0] s2;
  logic        sub;
  logic [63:0] res;
  logic        zero;
  logic        neg;
  logic        carry;
  logic        ovf;
  logic        lt;
  logic        ltu;

  int tests;
  int fails;

  ula_flags #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .s1    (s1),
    .s2    (s2),
    .sub   (sub),
    .res   (res),
    .zero  (zero),
    .neg   (neg),
    .carry (carry),
    .ovf   (ovf),
    .lt    (lt),
    .ltu   (ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {zero, neg, carry, ovf, lt, ltu}
  task automatic check(input string tag,
                       input logic [63:0] er,
                       input logic [5:0] ef);
    logic [5:0] f;
    f = {zero, neg, carry, ovf, lt, ltu};
    tests++;
    assert (res === er) else begin
      fails++;
      $error("FAIL %s res got %h expected %h", tag, res, er);
    end
    tests++;
    assert (f === ef) else begin
      fails++;
      $error("FAIL %s flags(z,n,c,v,lt,ltu) got %b expected %b",
             tag, f, ef);
    end
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b,
                     input logic op);
    @(negedge clk);
    s1  = a;
    s2  = b;
    sub = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    s1    = '0;
    s2    = '0;
    sub   = 1'b1;
    #12;
    check("reset", 64'd0, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    run(64'd1, -64'd45, 1'b1);
    check("1-(-45)", 64'd46, 6'b000001);
    run(64'd10000, 64'd5461, 1'b1);
    check("10000-5461", 64'd4539, 6'b001000);
    run(-64'd10000, -64'd4197, 1'b1);
    check("neg-neg", -64'd5803, 6'b010011);
    run(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("minneg-maxpos", 64'd1, 6'b001110);
    run(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFF8, 1'b1);
    check("swap_a", 64'd8, 6'b001110);
    run(64'h7FFF_FFFF_FFFF_FFF8, 64'h8000_0000_0000_0000, 1'b1);
    check("swap_b", 64'hFFFF_FFFF_FFFF_FFF8, 6'b010101);
    run(64'd12873481, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("uns_a", 64'd12873482, 6'b000001);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd12873481, 1'b1);
    check("uns_b", -64'd12873482, 6'b011010);
    run(64'd30, 64'd29, 1'b1);
    check("30-29", 64'd1, 6'b001000);
    run(64'd29, 64'd30, 1'b1);
    check("29-30", 64'hFFFF_FFFF_FFFF_FFFF, 6'b010011);
    run(64'd30, 64'd30, 1'b1);
    check("30-30", 64'd0, 6'b101000);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("add_wrap", 64'd0, 6'b101000);
    run(64'd100, 64'd23, 1'b0);
    check("add_plain", 64'd123, 6'b000001);

    // operands moving between edges must not disturb outputs
    #2;
    s1 = 64'd7;
    s2 = 64'd99;
    sub = 1'b1;
    #1;
    check("between_edges", 64'd123, 6'b000001);

    @(negedge clk);
    en = 1'b0;
    run(64'd5, 64'd9, 1'b1);
    check("hold_en0", 64'd123, 6'b000001);
    en = 1'b1;
    run(64'd5, 64'd9, 1'b1);
    check("after_hold", -64'd4, 6'b010011);

    // async reset between edges, with en unknown during reset
    #2;
    rst_n = 1'b0;
    en    = 1'bx;
    #1;
    check("async_rst", 64'd0, 6'b000000);
    @(posedge clk);
    #1;
    check("rst_hold", 64'd0, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    run(64'd30, 64'd29, 1'b1);
    check("post_rst", 64'd1, 6'b001000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
